divu_p4y2: RTL and testbench
============================

DIVU_P4Y2 -- requirements
Module: divu_p4y2

Interface
REQ-001 Parameter WIDTH_P, default 4, dividend and quotient width in bits.
REQ-002 Parameter WIDTH_Y, default 2, divisor and remainder width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a division; sampled on rising edge of clk.
REQ-006 p  input  WIDTH_P  unsigned dividend (a product from the mulu_x2y2 multiplier).
REQ-007 y  input  WIDTH_Y  unsigned divisor.
REQ-008 q  output  WIDTH_P  unsigned quotient.
REQ-009 r  output  WIDTH_Y  unsigned remainder.
REQ-010 dz  output  1  divide-by-zero flag for the current result.
REQ-011 busy  output  1  high while a division is in progress.
REQ-012 rdy  output  1  high while q, r and dz hold a completed result.

Function
REQ-013 The block SHALL be a restoring, bit-serial unsigned divider retiring one quotient bit per clock, MSB first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE, and no other state SHALL be reachable.
REQ-015 In IDLE or DONE with start=1 at an edge, the block SHALL latch p and y, clear the internal partial remainder (WIDTH_Y+1 bits) and the iteration counter, and enter RUN.
REQ-016 In RUN, each edge SHALL shift the next dividend bit into the partial remainder, subtract y when the shifted value is >= y (quotient bit 1), and otherwise keep it (quotient bit 0).
REQ-017 RUN SHALL last exactly WIDTH_P cycles, then enter DONE; rdy SHALL go high WIDTH_P edges after the start edge (4 for defaults).
REQ-018 Latency SHALL be constant and independent of operand values, including y=0.
REQ-019 If the latched y is 0, the block SHALL present q=all ones, r=0 and dz=1 in DONE; otherwise dz=0.
REQ-020 For y!=0, the block SHALL satisfy p = q*y + r with r < y, evaluated on the latched operands.
REQ-021 busy SHALL be 1 exactly in RUN; rdy SHALL be 1 exactly in DONE; busy and rdy SHALL never both be 1.
REQ-022 In DONE, q, r and dz SHALL hold steady until the next accepted start or reset.
REQ-023 start asserted in RUN SHALL be ignored, and changes to p and y during RUN SHALL NOT affect the result.
REQ-024 start asserted in DONE SHALL begin a new division: rdy falls and busy rises on the same edge.
REQ-025 q and r SHALL read 0 outside DONE.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE with q=0, r=0, dz=0, busy=0 and rdy=0, and clear the operand registers, partial remainder and counter.
REQ-027 reset SHALL take priority over start; an edge with both high SHALL leave the block in IDLE.
REQ-028 reset asserted during RUN SHALL abort the division, and no result SHALL appear afterwards.

Verification
REQ-029 The bench SHALL cover: p=15, y=3, start pulse -> busy for 4 cycles, then rdy=1 with q=5, r=0, dz=0.
REQ-030 The bench SHALL cover: p=13, y=2 -> q=6, r=1, dz=0, rdy 4 edges after start; q and r held for 10 idle cycles.
REQ-031 The bench SHALL cover: p=9, y=0 -> same latency, then q=15, r=0, dz=1.
REQ-032 The bench SHALL cover: start p=12, y=3, then p=7, y=1 and start=1 during RUN -> result q=4, r=0, with no restart.
REQ-033 The bench SHALL cover: reset on the 2nd RUN cycle of p=14, y=2 -> next cycle all outputs 0, state IDLE, and rdy stays 0 until a new start.
REQ-034 The bench SHALL cover: exhaustive sweep of all 64 (p, y) pairs with back-to-back starts issued in DONE -> every result matches a software reference, and rdy latency is always 4.

Source files
------------

// File: rtl/divu_p4y2_if.sv
// Handshake and data bundle for the bit-serial unsigned divider.
// The requester drives start and the operands; the divider returns the
// result together with its busy/rdy status.
interface divu_p4y2_if #(
    parameter int WIDTH_P = 4,
    parameter int WIDTH_Y = 2
);
    logic               start;
    logic [WIDTH_P-1:0] p;
    logic [WIDTH_Y-1:0] y;
    logic [WIDTH_P-1:0] q;
    logic [WIDTH_Y-1:0] r;
    logic               dz;
    logic               busy;
    logic               rdy;

    modport master (
        output start, p, y,
        input  q, r, dz, busy, rdy
    );

    modport slave (
        input  start, p, y,
        output q, r, dz, busy, rdy
    );
endinterface

// File: rtl/divu_p4y2.sv
// Restoring, bit-serial unsigned divider. One quotient bit is retired per
// clock, MSB first, so a division always takes WIDTH_P cycles in RUN no
// matter what the operands are. A zero divisor runs the same schedule and
// is flagged at the end with q=all ones, r=0, dz=1.
module divu_p4y2 #(
    parameter int WIDTH_P = 4,
    parameter int WIDTH_Y = 2
) (
    input  logic        clk,
    input  logic        reset,
    divu_p4y2_if.slave  bus
);

    localparam int CW = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH_P - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH_P-1:0]   p_reg;
    logic [WIDTH_Y-1:0]   y_reg;
    logic [WIDTH_Y:0]     rem;
    logic [WIDTH_P-1:0]   quo;
    logic [CW-1:0]        cnt;

    logic [WIDTH_Y+1:0]   shifted;
    logic [WIDTH_Y+1:0]   y_ext;
    logic                 take;
    logic [WIDTH_Y:0]     rem_next;
    logic [WIDTH_P-1:0]   quo_next;

    // One restoring step: bring down the next dividend bit, subtract the
    // divisor when it fits and record the resulting quotient bit.
    always_comb begin
        shifted  = {rem, p_reg[WIDTH_P-1]};
        y_ext    = {2'b00, y_reg};
        take     = (shifted >= y_ext);
        rem_next = take ? (WIDTH_Y+1)'(shifted - y_ext) : (WIDTH_Y+1)'(shifted);
        quo_next = WIDTH_P'({quo, take});
    end

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            p_reg    <= '0;
            y_reg    <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            bus.q    <= '0;
            bus.r    <= '0;
            bus.dz   <= 1'b0;
            bus.busy <= 1'b0;
            bus.rdy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        p_reg    <= bus.p;
                        y_reg    <= bus.y;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        bus.q    <= '0;
                        bus.r    <= '0;
                        bus.dz   <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.rdy  <= 1'b0;
                    end
                end
                RUN: begin
                    p_reg <= {p_reg[WIDTH_P-2:0], 1'b0};
                    rem   <= rem_next;
                    quo   <= quo_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.rdy  <= 1'b1;
                        bus.q    <= quo_next;
                        if (y_reg == '0) begin
                            bus.r  <= '0;
                            bus.dz <= 1'b1;
                        end else begin
                            bus.r  <= rem_next[WIDTH_Y-1:0];
                            bus.dz <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.rdy  <= 1'b0;
                    bus.q    <= '0;
                    bus.r    <= '0;
                    bus.dz   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_p4y2.sv
// Self-checking bench for divu_p4y2: directed scenarios followed by an
// exhaustive operand sweep with random operand noise during RUN, all
// compared against plain integer division.
module tb_divu_p4y2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    divu_p4y2_if #(.WIDTH_P(4), .WIDTH_Y(2)) bus ();

    divu_p4y2 #(.WIDTH_P(4), .WIDTH_Y(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic void refDiv(input int pv, input int yv,
                                   output int qe, output int re, output int dze);
        if (yv == 0) begin
            qe = 15; re = 0; dze = 1;
        end else begin
            qe = pv / yv; re = pv % yv; dze = 0;
        end
    endfunction

    function automatic logic [31:0] allOut();
        return 32'({bus.q, bus.r, bus.dz, bus.busy, bus.rdy});
    endfunction

    // Run one division; during RUN the operands are replaced (randomly or by
    // fixed values) and start may be held high, none of which may matter.
    task automatic applyStimulus(input logic [3:0] pv, input logic [1:0] yv,
                                 input logic [3:0] pr, input logic [1:0] yr,
                                 input bit rand_in_run, input bit start_in_run,
                                 input string tag);
        int lat;
        int qe, re, dze;
        @(negedge clk);
        bus.p = pv;
        bus.y = yv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = start_in_run;
        lat = 0;
        while (!bus.rdy && lat < 20) begin
            checkOutput({tag, " run status"}, 32'({bus.busy, bus.rdy, bus.q, bus.r}),
                        32'({1'b1, 1'b0, 4'd0, 2'd0}));
            if (rand_in_run) begin
                bus.p = 4'($urandom);
                bus.y = 2'($urandom);
            end else begin
                bus.p = pr;
                bus.y = yr;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        checkOutput({tag, " latency"}, 32'(lat), 32'd4);
        refDiv(int'(pv), int'(yv), qe, re, dze);
        checkOutput({tag, " q"}, 32'(bus.q), 32'(qe));
        checkOutput({tag, " r"}, 32'(bus.r), 32'(re));
        checkOutput({tag, " dz"}, 32'(bus.dz), 32'(dze));
        checkOutput({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.p = '0;
        bus.y = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", allOut(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset", allOut(), 32'd0);

        $display("[TB] p=15 y=3");
        applyStimulus(4'd15, 2'd3, 4'd15, 2'd3, 1'b0, 1'b0, "15/3");

        $display("[TB] p=13 y=2 with hold");
        applyStimulus(4'd13, 2'd2, 4'd13, 2'd2, 1'b0, 1'b0, "13/2");
        for (int i = 0; i < 10; i++) begin
            bus.p = 4'($urandom);
            bus.y = 2'($urandom);
            @(negedge clk);
            checkOutput("13/2 hold", 32'({bus.q, bus.r, bus.dz, bus.rdy, bus.busy}),
                        32'({4'd6, 2'd1, 1'b0, 1'b1, 1'b0}));
        end

        $display("[TB] p=9 y=0");
        applyStimulus(4'd9, 2'd0, 4'd9, 2'd0, 1'b0, 1'b0, "9/0");

        $display("[TB] p=12 y=3 with operand change and start in RUN");
        applyStimulus(4'd12, 2'd3, 4'd7, 2'd1, 1'b0, 1'b1, "12/3 noisy");
        @(negedge clk);
        checkOutput("12/3 no restart", 32'({bus.busy, bus.rdy, bus.q}),
                    32'({1'b0, 1'b1, 4'd4}));

        $display("[TB] reset during RUN");
        @(negedge clk);
        bus.p = 4'd14;
        bus.y = 2'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort outputs", allOut(), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort stays idle", 32'({bus.busy, bus.rdy}), 32'd0);
        end

        $display("[TB] reset has priority over start");
        bus.p = 4'd5;
        bus.y = 2'd1;
        bus.start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        checkOutput("reset over start", allOut(), 32'd0);
        @(negedge clk);
        checkOutput("reset over start later", allOut(), 32'd0);

        $display("[TB] exhaustive sweep");
        for (int pv = 0; pv < 16; pv++) begin
            for (int yv = 0; yv < 4; yv++) begin
                applyStimulus(4'(pv), 2'(yv), 4'd0, 2'd0, 1'b1,
                              1'($urandom_range(0, 1)), "sweep");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
